call_stack: RTL
===============

# call_stack

Hardware return-address stack feeding the program counter. On a call it pushes the return address (current PC + 1). On a return it pops the top entry and presents it with a one-cycle load strobe, which the program counter consumes as its stack-pop load. It sits between the instruction decoder (call/ret strobes) and the PC. It is the writer side of the PC's stack-pop load path.

## Interface
- AW, 16: address width; must equal PC width.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- clk  in  1  clock; block updates on posedge (PC samples on negedge).
- rst  in  1  reset, asynchronous, active-low.
- call  in  1  push request, one-cycle strobe from decoder.
- ret  in  1  pop request, one-cycle strobe from decoder.
- pc  in  AW  current PC value at the call instruction.
- clr_err  in  1  synchronous clear of ovf/unf.
- ret_addr  out  AW  popped return address (registered).
- pop_valid  out  1  one-cycle strobe; drives PC write-enable and stack-pop select.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf  out  1  sticky: push attempted while full.
- unf  out  1  sticky: pop attempted while empty.

## Operation
- Storage: DEPTH×AW register file, top pointer sp (index of next free slot), occupancy count.
- Occupancy states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH). Transitions follow count changes only.
- Push (call=1, ret=0):
  - Computes pc+1 modulo 2^AW; 16'hFFFF pushes 16'h0000.
  - Writes it to mem[sp]; sp and count increment.
- Pop (ret=1, call=0, not empty):
  - ret_addr ← mem[sp-1]; sp and count decrement.
  - pop_valid=1 for exactly the following cycle.
- Pop while empty:
  - Sets unf; pop_valid stays 0; ret_addr holds.
  - sp and count are unchanged.
- Push while full: sets ovf; remaining behaviour is set by the macro (see Configuration).
- call and ret in the same cycle (tail call/replace):
  - If not empty: ret_addr ← old top, pop_valid=1, top overwritten with pc+1; count unchanged.
  - If empty: unf set, pc+1 pushed, count becomes 1, no pop_valid.
- clr_err clears ovf/unf. If an error event occurs in the same cycle, the event wins and the flag is set.
- sp arithmetic wraps modulo DEPTH.

## Timing
- Reset values: ret_addr=0, pop_valid=0, count=0, empty=1, full=0, ovf=0, unf=0, sp=0. Memory contents are not reset.
- Pop latency: ret sampled at posedge N → ret_addr/pop_valid valid after posedge N. The PC loads at the negedge between N and N+1. pop_valid drops after posedge N+1 unless ret is repeated.
- Back-to-back ret on consecutive cycles: pop_valid is held high for both cycles, with a distinct ret_addr each cycle.
- Push has no output latency: count/full update after the sampling posedge. A pop in the next cycle returns the just-pushed value.
- Reset asserted mid-operation clears state immediately, including an in-flight pop_valid. The PC must see no load.

## Configuration
- CALL_STACK_WRAP_EN defined: push while full overwrites the oldest entry (circular). sp advances, count saturates at DEPTH, ovf is set. The stack keeps the newest DEPTH return addresses.
- Not defined: push while full is dropped. Memory, sp and count are unchanged; ovf is set.

## Structure
- Package call_stack_pkg: default AW/DEPTH constants, pointer-width localparam, occupancy-state enum (EMPTY/PARTIAL/FULL).
- Sub-module call_stack_mem: DEPTH×AW register file with one synchronous write port and one asynchronous read port. The top level holds pointers, flags and output registers.

## Test plan
- Reset, then call with pc=0x0010, then ret → pop_valid one cycle, ret_addr=0x0011, empty=1 afterward.
- Push 3 calls (pc=0x100, 0x200, 0x300), then 3 consecutive rets → ret_addr 0x301, 0x201, 0x101 on consecutive cycles with pop_valid held; then ret on empty → unf=1, pop_valid=0, ret_addr stays 0x101.
- Fill DEPTH=16 with pc=0..15, then call pc=0x99:
  - Without macro: ovf=1, count=16, subsequent pops return 16..1.
  - With macro: ovf=1, first pop returns 0x9A, the last pop returns 2.
- Simultaneous call(pc=0x500)+ret with top=0x41 → ret_addr=0x41, pop_valid=1, count unchanged, next pop returns 0x501.
- call with pc=0xFFFF, then ret → ret_addr=0x0000. Then assert rst while a ret strobe is active → pop_valid=0, count=0 immediately.

Source files
------------

// File: rtl/call_stack_pkg.sv
// Shared constants and occupancy-state type for the return-address stack.
package call_stack_pkg;

  localparam int unsigned DefaultAw    = 16;
  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned DefaultPtrW  = $clog2(DefaultDepth);

  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_e;

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x AW register file: one synchronous write port, one asynchronous read port.
module call_stack_mem #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [AW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [AW-1:0]            rdata_o
);

  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Return-address stack feeding the PC stack-pop load path.
// Define CALL_STACK_WRAP_EN to overwrite the oldest entry on push-while-full.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int unsigned AW    = DefaultAw,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     call_i,
  input  logic                     ret_i,
  input  logic [AW-1:0]            pc_i,
  input  logic                     clr_err_i,
  output logic [AW-1:0]            ret_addr_o,
  output logic                     pop_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     ovf_o,
  output logic                     unf_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [PtrW-1:0] sp_q, sp_d, sp_dec, wr_addr;
  logic [CntW-1:0] count_q, count_d;
  logic [AW-1:0]   ret_addr_q, ret_addr_d, push_val, top_val;
  logic            pop_valid_q, pop_valid_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            we;
  logic            is_empty, is_full;
  occ_e            occ_q, occ_d;

  assign is_empty = (occ_q == OccEmpty);
  assign is_full  = (occ_q == OccFull);
  assign push_val = pc_i + AW'(1);
  assign sp_dec   = sp_q - PtrW'(1);

  call_stack_mem #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (wr_addr),
    .wdata_i (push_val),
    .raddr_i (sp_dec),
    .rdata_o (top_val)
  );

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    ret_addr_d  = ret_addr_q;
    pop_valid_d = 1'b0;
    // An error event in the same cycle as clr_err wins over the clear.
    ovf_d       = ovf_q & ~clr_err_i;
    unf_d       = unf_q & ~clr_err_i;
    we          = 1'b0;
    wr_addr     = sp_q;

    case ({call_i, ret_i})
      2'b10: begin
        if (!is_full) begin
          we      = 1'b1;
          sp_d    = sp_q + PtrW'(1);
          count_d = count_q + CntW'(1);
        end else begin
          ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          // When full, sp points at the oldest slot, so this overwrites it.
          we   = 1'b1;
          sp_d = sp_q + PtrW'(1);
`endif
        end
      end
      2'b01: begin
        if (!is_empty) begin
          ret_addr_d  = top_val;
          pop_valid_d = 1'b1;
          sp_d        = sp_dec;
          count_d     = count_q - CntW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          // Tail call: hand back the old top and replace it in place.
          ret_addr_d  = top_val;
          pop_valid_d = 1'b1;
          we          = 1'b1;
          wr_addr     = sp_dec;
        end else begin
          unf_d   = 1'b1;
          we      = 1'b1;
          sp_d    = sp_q + PtrW'(1);
          count_d = count_q + CntW'(1);
        end
      end
      default: ;
    endcase

    if (count_d == '0) begin
      occ_d = OccEmpty;
    end else if (count_d == CntFull) begin
      occ_d = OccFull;
    end else begin
      occ_d = OccPartial;
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      occ_q       <= OccEmpty;
      sp_q        <= '0;
      count_q     <= '0;
      ret_addr_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      sp_q        <= sp_d;
      count_q     <= count_d;
      ret_addr_q  <= ret_addr_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign ret_addr_o  = ret_addr_q;
  assign pop_valid_o = pop_valid_q;
  assign count_o     = count_q;
  assign empty_o     = is_empty;
  assign full_o      = is_full;
  assign ovf_o       = ovf_q;
  assign unf_o       = unf_q;

endmodule
